// File: rtl/cv32e40p_instr_encoder_if.sv
// Instruction stream from the encoder FIFO head to a decoder-side consumer.
interface cv32e40p_instr_encoder_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic [3:0]  instr_class;

  modport master (
    output instr_valid,
    output instr_rdata,
    output instr_class,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_rdata,
    input  instr_class,
    output instr_ready
  );
endinterface

// File: rtl/cv32e40p_instr_encoder.sv
// LFSR-driven RV32I instruction encoder with an output FIFO.
// Optional illegal-word injection: define CV32E40P_ENC_ILLEGAL_INJ_EN.
module cv32e40p_instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [15:0]                      count_i,
  input  logic                             seed_load_i,
  input  logic [31:0]                      seed_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [15:0]                      gen_cnt_o,
  cv32e40p_instr_encoder_if.master         instr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StGen, StDrain} state_e;

  state_e        state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [15:0]   gen_cnt_q, gen_cnt_d;
  logic [15:0]   count_q, count_d;
  logic          done_q, done_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;

  logic [31:0]   mem_word [FIFO_DEPTH];
  logic [3:0]    mem_class [FIFO_DEPTH];

  logic          push, pop, full, empty;
  logic [31:0]   lfsr_step;
  logic [31:0]   enc_word;
  logic [3:0]    enc_class;
  logic [2:0]    f3;
  logic [6:0]    hi7, opc;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == FullCnt);
  assign pop   = !empty && instr.instr_ready;
  assign push  = (state_q == StGen) && (!full || pop);

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8020_0003) : (lfsr_q >> 1);

  // Legalize the raw LFSR fields into a word of the selected class.
  always_comb begin
    f3        = lfsr_q[14:12];
    hi7       = lfsr_q[31:25];
    opc       = 7'b0000000;
    enc_class = {1'b0, lfsr_q[2:0]};
    unique case (lfsr_q[2:0])
      3'd0: begin
        opc = 7'b0110011;
        hi7 = {1'b0, lfsr_q[30] & ((f3 == 3'd0) | (f3 == 3'd5)), 5'b0};
      end
      3'd1: begin
        opc = 7'b0010011;
        if (f3 == 3'd1) hi7 = 7'b0;
        else if (f3 == 3'd5) hi7 = {1'b0, lfsr_q[30], 5'b0};
      end
      3'd2: begin
        opc = 7'b0000011;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'd2;
      end
      3'd3: begin
        opc = 7'b0100011;
        f3  = (lfsr_q[13:12] == 2'd3) ? 3'd2 : {1'b0, lfsr_q[13:12]};
      end
      3'd4: begin
        opc = 7'b1100011;
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
      end
      3'd5: opc = 7'b0110111;
      3'd6: opc = 7'b1101111;
      3'd7: begin
        // Nonzero funct3 keeps ECALL/EBREAK/MRET/WFI out of the stream.
        opc = 7'b1110011;
        if (f3 == 3'd0 || f3 == 3'd4) f3 = 3'd1;
      end
      default: opc = 7'b0000000;
    endcase
    enc_word = {hi7, lfsr_q[24:15], f3, lfsr_q[11:7], opc};
`ifdef CV32E40P_ENC_ILLEGAL_INJ_EN
    if (gen_cnt_q[3:0] == 4'hF) begin
      enc_word  = 32'h0000_0000;
      enc_class = 4'hF;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    gen_cnt_d = gen_cnt_q;
    count_d   = count_q;
    done_d    = 1'b0;
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop  ? rptr_q + 1'b1 : rptr_q;
    occ_d     = occ_q;
    if (push && !pop) occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;

    case (state_q)
      StIdle: begin
        if (seed_load_i) lfsr_d = (seed_i == 32'h0) ? SEED : seed_i;
        if (start_i) begin
          count_d   = count_i;
          gen_cnt_d = 16'h0;
          state_d   = (count_i == 16'h0) ? StDrain : StGen;
        end
      end
      StGen: begin
        if (push) begin
          lfsr_d    = lfsr_step;
          gen_cnt_d = gen_cnt_q + 16'd1;
          if (gen_cnt_q + 16'd1 == count_q) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leaving on the cycle the FIFO goes empty makes done_o land right after the last pop.
        if (occ_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      lfsr_q    <= SEED;
      gen_cnt_q <= 16'h0;
      count_q   <= 16'h0;
      done_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      gen_cnt_q <= gen_cnt_d;
      count_q   <= count_d;
      done_q    <= done_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_word[wptr_q]  <= enc_word;
      mem_class[wptr_q] <= enc_class;
    end
  end

  assign instr.instr_valid = !empty;
  assign instr.instr_rdata = empty ? 32'h0 : mem_word[rptr_q];
  assign instr.instr_class = empty ? 4'h0 : mem_class[rptr_q];
  assign busy_o            = (state_q != StIdle);
  assign done_o            = done_q;
  assign gen_cnt_o         = gen_cnt_q;

endmodule
